// File: rtl/acorn_pkg.sv
// ---------------------------------------------------------------------------
// acorn_pkg
// Shared types and constants for the ACORN-128 phase sequencer.
//   phase_e     : controller state; the low three bits are the externally
//                 visible phase code, DONE lives above them and reports as 7
//   *_C         : step counts of the fixed-length phases
//   phase_code  : maps a state onto the 3-bit phase_o encoding
// Optional build macro used by the files importing this package:
//   ACORN_DECRYPT_EN
// ---------------------------------------------------------------------------
package acorn_pkg;

    typedef enum logic [3:0] {
        PH_IDLE    = 4'd0,
        PH_LOAD    = 4'd1,
        PH_INIT    = 4'd2,
        PH_AD      = 4'd3,
        PH_AD_PAD  = 4'd4,
        PH_ENC     = 4'd5,
        PH_ENC_PAD = 4'd6,
        PH_FIN     = 4'd7,
        PH_DONE    = 4'd8
    } phase_e;

    localparam int PHASE_W     = 3;
    localparam int STEP_W      = 11;
    localparam int INIT_STEPS_C = 1792;
    localparam int PAD_STEPS_C  = 256;
    localparam int PAD_HALF_C   = 128;
    localparam int FIN_STEPS_C  = 768;
    localparam int TAG_START_C  = 640;

    // DONE has no code of its own on phase_o; it reads as FIN together with done_o.
    function automatic logic [PHASE_W-1:0] phase_code(input phase_e s);
        logic [3:0] raw;
        raw = s;
        return (s == PH_DONE) ? 3'd7 : raw[2:0];
    endfunction

endpackage

// File: rtl/acorn_phase_ctrl_if.sv
// ---------------------------------------------------------------------------
// acorn_phase_ctrl_if
// Bundles every non-clock/reset signal of acorn_phase_ctrl.
//   master : host / datapath side (drives start, key, iv, lengths, streams, ks)
//   slave  : the sequencer (drives datapath controls, ct stream, tag, status)
// Signal suffixes are from the sequencer's point of view (_i in, _o out).
// Build macro: ACORN_DECRYPT_EN adds dec_i.
// ---------------------------------------------------------------------------
interface acorn_phase_ctrl_if
    import acorn_pkg::*;
#(
    parameter int AD_LEN_W  = 16,
    parameter int MSG_LEN_W = 16
);
    logic                 start_i;
    logic [127:0]         key_i;
    logic [127:0]         iv_i;
    logic [AD_LEN_W-1:0]  ad_len_i;
    logic [MSG_LEN_W-1:0] msg_len_i;
`ifdef ACORN_DECRYPT_EN
    logic                 dec_i;
`endif
    logic                 ad_bit_i;
    logic                 ad_valid_i;
    logic                 ad_ready_o;
    logic                 pt_bit_i;
    logic                 pt_valid_i;
    logic                 pt_ready_o;
    logic                 ks_bit_i;
    logic                 state_clr_o;
    logic                 step_o;
    logic                 mbit_o;
    logic                 ca_o;
    logic                 cb_o;
    logic                 ct_bit_o;
    logic                 ct_valid_o;
    logic [127:0]         tag_o;
    logic                 tag_valid_o;
    logic                 busy_o;
    logic                 done_o;
    logic [PHASE_W-1:0]   phase_o;

    modport master (
`ifdef ACORN_DECRYPT_EN
        output dec_i,
`endif
        output start_i, key_i, iv_i, ad_len_i, msg_len_i,
        output ad_bit_i, ad_valid_i, pt_bit_i, pt_valid_i, ks_bit_i,
        input  ad_ready_o, pt_ready_o, state_clr_o, step_o, mbit_o, ca_o, cb_o,
        input  ct_bit_o, ct_valid_o, tag_o, tag_valid_o, busy_o, done_o, phase_o
    );

    modport slave (
`ifdef ACORN_DECRYPT_EN
        input  dec_i,
`endif
        input  start_i, key_i, iv_i, ad_len_i, msg_len_i,
        input  ad_bit_i, ad_valid_i, pt_bit_i, pt_valid_i, ks_bit_i,
        output ad_ready_o, pt_ready_o, state_clr_o, step_o, mbit_o, ca_o, cb_o,
        output ct_bit_o, ct_valid_o, tag_o, tag_valid_o, busy_o, done_o, phase_o
    );
endinterface

// File: rtl/acorn_init_mbit.sv
// ---------------------------------------------------------------------------
// acorn_init_mbit
// Combinational message-bit selector for the initialization phase.
//   key_i  : 128-bit key
//   iv_i   : 128-bit IV
//   step_i : initialization step index (0..1791)
//   mbit_o : message bit injected at that step
// Steps 0..127 load the key, 128..255 the IV, step 256 the key's first bit
// inverted (domain separation), then the key repeats cyclically.
// ---------------------------------------------------------------------------
module acorn_init_mbit
    import acorn_pkg::*;
(
    input  logic [127:0]      key_i,
    input  logic [127:0]      iv_i,
    input  logic [STEP_W-1:0] step_i,
    output logic              mbit_o
);

    // The low seven step bits are step mod 128, which indexes both the key
    // stream and the IV stream.
    always_comb begin
        mbit_o = key_i[step_i[6:0]];
        if (step_i < STEP_W'(128)) begin
            mbit_o = key_i[step_i[6:0]];
        end else if (step_i < STEP_W'(256)) begin
            mbit_o = iv_i[step_i[6:0]];
        end else if (step_i == STEP_W'(256)) begin
            mbit_o = ~key_i[0];
        end
    end

endmodule

// File: rtl/acorn_phase_ctrl.sv
// ---------------------------------------------------------------------------
// acorn_phase_ctrl
// Phase sequencer for the ACORN-128 state-update datapath: decides each
// cycle whether the datapath steps and supplies that step's mbit/ca/cb,
// walking LOAD, INIT, AD, AD_PAD, ENC, ENC_PAD, FIN and DONE.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : acorn_phase_ctrl_if.slave (start/key/iv/lengths, AD and
//              plaintext streams, keystream bit, datapath controls,
//              ciphertext stream, tag, busy/done/phase status)
// Build macro: ACORN_DECRYPT_EN (adds dec_i; ENC then consumes ciphertext).
// ---------------------------------------------------------------------------
module acorn_phase_ctrl
    import acorn_pkg::*;
#(
    parameter int AD_LEN_W   = 16,
    parameter int MSG_LEN_W  = 16,
    parameter int INIT_STEPS = INIT_STEPS_C,
    parameter int PAD_STEPS  = PAD_STEPS_C,
    parameter int FIN_STEPS  = FIN_STEPS_C
)(
    input  logic              clk,
    input  logic              rst,
    acorn_phase_ctrl_if.slave bus
);

    localparam int CNT_W = (AD_LEN_W > MSG_LEN_W) ? AD_LEN_W : MSG_LEN_W;

    phase_e               state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [CNT_W-1:0]     bits_q, bits_d;
    logic [AD_LEN_W-1:0]  ad_len_q, ad_len_d;
    logic [MSG_LEN_W-1:0] msg_len_q, msg_len_d;
    logic                 tag_valid_q, tag_valid_d;
    logic [127:0]         tag_q;
    logic                 tag_we;
    logic                 init_mbit;
    logic                 enc_mbit;
    logic [CNT_W-1:0]     ad_last, msg_last;

    acorn_init_mbit u_init_mbit (
        .key_i  (bus.key_i),
        .iv_i   (bus.iv_i),
        .step_i (step_q),
        .mbit_o (init_mbit)
    );

    // Index of the final accepted bit; only used while the length is non-zero.
    assign ad_last  = CNT_W'(ad_len_q)  - CNT_W'(1);
    assign msg_last = CNT_W'(msg_len_q) - CNT_W'(1);

`ifdef ACORN_DECRYPT_EN
    logic dec_q, dec_d;
    // When decrypting, the stream carries ciphertext; the datapath absorbs the
    // recovered plaintext.
    assign enc_mbit = dec_q ? (bus.pt_bit_i ^ bus.ks_bit_i) : bus.pt_bit_i;
`else
    assign enc_mbit = bus.pt_bit_i;
`endif

    // Next-state and per-cycle datapath controls. Both counters restart at
    // zero whenever the state changes.
    always_comb begin
        state_d         = state_q;
        step_d          = step_q;
        bits_d          = bits_q;
        ad_len_d        = ad_len_q;
        msg_len_d       = msg_len_q;
        tag_valid_d     = tag_valid_q;
`ifdef ACORN_DECRYPT_EN
        dec_d           = dec_q;
`endif
        tag_we          = 1'b0;
        bus.state_clr_o = 1'b0;
        bus.step_o      = 1'b0;
        bus.mbit_o      = 1'b0;
        bus.ca_o        = 1'b0;
        bus.cb_o        = 1'b0;
        bus.ct_bit_o    = 1'b0;
        bus.ct_valid_o  = 1'b0;
        bus.ad_ready_o  = 1'b0;
        bus.pt_ready_o  = 1'b0;
        bus.done_o      = 1'b0;

        unique case (state_q)
            PH_IDLE: begin
                if (bus.start_i) begin
                    state_d     = PH_LOAD;
                    ad_len_d    = bus.ad_len_i;
                    msg_len_d   = bus.msg_len_i;
                    tag_valid_d = 1'b0;
`ifdef ACORN_DECRYPT_EN
                    dec_d       = bus.dec_i;
`endif
                end
            end
            PH_LOAD: begin
                bus.state_clr_o = 1'b1;
                state_d         = PH_INIT;
            end
            PH_INIT: begin
                bus.step_o = 1'b1;
                bus.mbit_o = init_mbit;
                bus.ca_o   = 1'b1;
                bus.cb_o   = 1'b1;
                step_d     = step_q + STEP_W'(1);
                if (step_q == STEP_W'(INIT_STEPS - 1)) begin
                    state_d = (ad_len_q == '0) ? PH_AD_PAD : PH_AD;
                end
            end
            PH_AD: begin
                bus.ad_ready_o = 1'b1;
                bus.step_o     = bus.ad_valid_i;
                bus.mbit_o     = bus.ad_bit_i;
                bus.ca_o       = 1'b1;
                bus.cb_o       = 1'b1;
                if (bus.ad_valid_i) begin
                    bits_d = bits_q + CNT_W'(1);
                    if (bits_q == ad_last) begin
                        state_d = PH_AD_PAD;
                    end
                end
            end
            PH_AD_PAD, PH_ENC_PAD: begin
                // A single 1 opens the padding; ca covers only its first half.
                bus.step_o = 1'b1;
                bus.mbit_o = (step_q == '0);
                bus.ca_o   = (step_q < STEP_W'(PAD_HALF_C));
                bus.cb_o   = (state_q == PH_AD_PAD);
                step_d     = step_q + STEP_W'(1);
                if (step_q == STEP_W'(PAD_STEPS - 1)) begin
                    if (state_q == PH_ENC_PAD) begin
                        state_d = PH_FIN;
                    end else begin
                        state_d = (msg_len_q == '0) ? PH_ENC_PAD : PH_ENC;
                    end
                end
            end
            PH_ENC: begin
                bus.pt_ready_o = 1'b1;
                bus.step_o     = bus.pt_valid_i;
                bus.mbit_o     = enc_mbit;
                bus.ca_o       = 1'b1;
                bus.ct_bit_o   = bus.pt_bit_i ^ bus.ks_bit_i;
                bus.ct_valid_o = bus.pt_valid_i;
                if (bus.pt_valid_i) begin
                    bits_d = bits_q + CNT_W'(1);
                    if (bits_q == msg_last) begin
                        state_d = PH_ENC_PAD;
                    end
                end
            end
            PH_FIN: begin
                bus.step_o = 1'b1;
                bus.ca_o   = 1'b1;
                bus.cb_o   = 1'b1;
                tag_we     = (step_q >= STEP_W'(TAG_START_C));
                step_d     = step_q + STEP_W'(1);
                if (step_q == STEP_W'(FIN_STEPS - 1)) begin
                    state_d     = PH_DONE;
                    tag_valid_d = 1'b1;
                end
            end
            PH_DONE: begin
                bus.done_o = 1'b1;
                state_d    = PH_IDLE;
            end
            default: begin
                state_d = PH_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            step_d = '0;
            bits_d = '0;
        end
    end

    // State, counters, latched lengths and the tag shift-in. The tag window
    // starts at a multiple of 128, so the low seven step bits are the tag index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PH_IDLE;
            step_q      <= '0;
            bits_q      <= '0;
            ad_len_q    <= '0;
            msg_len_q   <= '0;
            tag_valid_q <= 1'b0;
            tag_q       <= '0;
`ifdef ACORN_DECRYPT_EN
            dec_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            bits_q      <= bits_d;
            ad_len_q    <= ad_len_d;
            msg_len_q   <= msg_len_d;
            tag_valid_q <= tag_valid_d;
`ifdef ACORN_DECRYPT_EN
            dec_q       <= dec_d;
`endif
            if (tag_we) begin
                tag_q[step_q[6:0]] <= bus.ks_bit_i;
            end
        end
    end

    assign bus.tag_o       = tag_q;
    assign bus.tag_valid_o = tag_valid_q;
    assign bus.busy_o      = (state_q != PH_IDLE);
    assign bus.phase_o     = phase_code(state_q);

endmodule

// File: tb/tb_acorn_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_acorn_phase_ctrl
// Self-checking bench for acorn_phase_ctrl. Each operation is driven with
// randomized streams, valids, keystream bits and stray start pulses; every
// datapath step is logged and compared against a phase-by-phase model of
// the expected (mbit, ca, cb, phase) sequence, plus ciphertext, tag, latency
// and reset behaviour. Build macro ACORN_DECRYPT_EN enables the decrypt run.
// ---------------------------------------------------------------------------
module tb_acorn_phase_ctrl;

    typedef struct packed {
        logic       mbit;
        logic       ca;
        logic       cb;
        logic [2:0] phase;
    } step_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    acorn_phase_ctrl_if bus ();

    acorn_phase_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [127:0] key, iv;
    bit    adBits[$];
    bit    ptBits[$];
    step_t stepLog[$];
    bit    ksLog[$];
    bit    ctObs[$];
    bit    ctExp[$];
    int    doneCycle, clrCount, clrCycle;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Message bit absorbed at initialization step i.
    function automatic bit initMbit(input int i);
        if (i < 128) return key[i];
        if (i < 256) return iv[i - 128];
        if (i == 256) return ~key[0];
        return key[i % 128];
    endfunction

    // Expected k-th datapath step of one whole operation.
    function automatic step_t expStep(input int k, input int adLen, input int msgLen);
        step_t s;
        int j;
        s.mbit = 1'b0; s.ca = 1'b1; s.cb = 1'b1; s.phase = 3'd7;
        if (k < 1792) begin
            s.mbit = initMbit(k); s.phase = 3'd2; return s;
        end
        j = k - 1792;
        if (j < adLen) begin
            s.mbit = adBits[j]; s.phase = 3'd3; return s;
        end
        j -= adLen;
        if (j < 256) begin
            s.mbit = (j == 0); s.ca = (j < 128); s.phase = 3'd4; return s;
        end
        j -= 256;
        if (j < msgLen) begin
            s.mbit = ptBits[j]; s.cb = 1'b0; s.phase = 3'd5; return s;
        end
        j -= msgLen;
        if (j < 256) begin
            s.mbit = (j == 0); s.ca = (j < 128); s.cb = 1'b0; s.phase = 3'd6; return s;
        end
        return s;
    endfunction

    // One operation: start, then per cycle drive inputs, settle, log outputs.
    // validPct < 0 alternates valids; ksMode 1 holds the keystream at 1.
    task automatic applyStimulus(input int adLen, input int msgLen, input int validPct,
                                 input int ksMode, input bit decMode, input int abortAt);
        int adIdx = 0;
        int ptIdx = 0;
        int budget;
        bit ks, plain, alt;
        step_t s;
        alt = 1'b1;
        adBits.delete(); ptBits.delete(); stepLog.delete(); ksLog.delete();
        ctObs.delete(); ctExp.delete();
        doneCycle = -1; clrCount = 0; clrCycle = -1;
        for (int i = 0; i < adLen; i++) adBits.push_back(1'($urandom));
        for (int i = 0; i < msgLen; i++) ptBits.push_back(1'($urandom));
        budget = 3300 + 20 * (adLen + msgLen);

        bus.key_i     = key;
        bus.iv_i      = iv;
        bus.ad_len_i  = 16'(adLen);
        bus.msg_len_i = 16'(msgLen);
`ifdef ACORN_DECRYPT_EN
        bus.dec_i     = decMode;
`endif
        bus.start_i   = 1'b1;
        @(posedge clk); #1;
        bus.start_i   = 1'b0;

        for (int c = 1; c <= budget; c++) begin
            ks = (ksMode == 1) ? 1'b1 : 1'($urandom);
            bus.ks_bit_i   = ks;
            bus.ad_valid_i = (validPct < 0) ? alt : (($urandom % 100) < validPct);
            bus.pt_valid_i = (validPct < 0) ? alt : (($urandom % 100) < validPct);
            alt = ~alt;
            bus.ad_bit_i   = (adIdx < adLen) ? adBits[adIdx] : 1'($urandom);
            plain          = (ptIdx < msgLen) ? ptBits[ptIdx] : 1'($urandom);
            bus.pt_bit_i   = decMode ? (plain ^ ks) : plain;
            bus.start_i    = (($urandom % 64) == 0);
            #1;
            if (bus.state_clr_o) begin
                clrCount++;
                clrCycle = c;
            end
            if (bus.step_o) begin
                s.mbit = bus.mbit_o; s.ca = bus.ca_o; s.cb = bus.cb_o; s.phase = bus.phase_o;
                stepLog.push_back(s);
                ksLog.push_back(ks);
            end
            if (bus.ct_valid_o) begin
                ctObs.push_back(bus.ct_bit_o);
                ctExp.push_back(decMode ? plain : (plain ^ ks));
            end
            if (bus.ad_valid_i && bus.ad_ready_o) adIdx++;
            if (bus.pt_valid_i && bus.pt_ready_o) ptIdx++;
            if (c == abortAt) begin
                checkOutput("abort_in_fin", 128'(bus.phase_o), 128'(7));
                rst = 1'b1;
                #1;
                checkOutput("rst_flags", 128'({bus.busy_o, bus.done_o, bus.tag_valid_o, bus.step_o,
                            bus.state_clr_o, bus.ca_o, bus.cb_o, bus.mbit_o, bus.phase_o}), 128'(0));
                checkOutput("rst_tag", bus.tag_o, 128'(0));
                bus.start_i = 1'b0; bus.ad_valid_i = 1'b0; bus.pt_valid_i = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (bus.done_o) begin
                doneCycle = c;
                checkOutput("done_phase_tagvalid", 128'({bus.phase_o, bus.tag_valid_o}), 128'({3'd7, 1'b1}));
                break;
            end
            @(posedge clk); #1;
        end
        bus.start_i = 1'b0; bus.ad_valid_i = 1'b0; bus.pt_valid_i = 1'b0;
        checkOutput("done_seen", 128'(doneCycle > 0), 128'(1));
        @(posedge clk); #1;
        checkOutput("after_done", 128'({bus.done_o, bus.busy_o, bus.tag_valid_o, bus.phase_o}),
                    128'({1'b0, 1'b0, 1'b1, 3'd0}));
    endtask

    // Compare the logged run against the model.
    task automatic checkRun(input int adLen, input int msgLen);
        int total, bad, firstBad, n;
        logic [127:0] expTag;
        total = 1792 + adLen + 256 + msgLen + 256 + 768;
        checkOutput("step_count", 128'(stepLog.size()), 128'(total));
        bad = 0; firstBad = -1;
        n = (stepLog.size() < total) ? stepLog.size() : total;
        for (int k = 0; k < n; k++) begin
            if (stepLog[k] !== expStep(k, adLen, msgLen)) begin
                if (firstBad < 0) firstBad = k;
                bad++;
            end
        end
        checkOutput($sformatf("step_content(first@%0d)", firstBad), 128'(bad), 128'(0));
        checkOutput("ct_count", 128'(ctObs.size()), 128'(msgLen));
        bad = 0;
        for (int j = 0; j < ctObs.size(); j++) if (ctObs[j] !== ctExp[j]) bad++;
        checkOutput("ct_content", 128'(bad), 128'(0));
        expTag = '0;
        if (ksLog.size() >= total)
            for (int j = 0; j < 128; j++) expTag[j] = ksLog[total - 128 + j];
        checkOutput("tag", bus.tag_o, expTag);
        checkOutput("load_cycles", 128'({clrCount[7:0], clrCycle[7:0]}), 128'({8'd1, 8'd1}));
    endtask

    initial begin
        int ones, adL, msL;
        logic [13:0] obs14;
        logic [7:0]  obs8, exp8;

        bus.start_i = 1'b0; bus.key_i = '0; bus.iv_i = '0;
        bus.ad_len_i = '0; bus.msg_len_i = '0;
        bus.ad_bit_i = 1'b0; bus.ad_valid_i = 1'b0;
        bus.pt_bit_i = 1'b0; bus.pt_valid_i = 1'b0; bus.ks_bit_i = 1'b0;
`ifdef ACORN_DECRYPT_EN
        bus.dec_i = 1'b0;
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_flags", 128'({bus.busy_o, bus.done_o, bus.tag_valid_o, bus.step_o,
                    bus.state_clr_o, bus.ad_ready_o, bus.pt_ready_o, bus.ct_valid_o, bus.phase_o}), 128'(0));
        checkOutput("reset_tag", bus.tag_o, 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero key/IV, empty AD and message: fixed latency, single 1 at step 256.
        $display("[TB] run: zero key, empty AD/message");
        key = '0; iv = '0;
        applyStimulus(0, 0, 50, 0, 1'b0, 0);
        checkRun(0, 0);
        // The edge that samples start counts as cycle 1.
        checkOutput("latency", 128'(doneCycle), 128'(3074));
        ones = 0;
        for (int k = 0; k < 1792 && k < stepLog.size(); k++) ones += int'(stepLog[k].mbit);
        checkOutput("init_ones_zero_key", 128'(ones), 128'(1));
        checkOutput("init_step256", 128'(stepLog.size() > 256 ? stepLog[256].mbit : 1'b0), 128'(1));

        // key = 1: ones at every multiple of 128 except 128 (IV) and 256 (inverted).
        $display("[TB] run: key=1");
        key = 128'h1; iv = '0;
        applyStimulus(5, 4, 70, 0, 1'b0, 0);
        checkRun(5, 4);
        obs14 = '0;
        for (int m = 0; m < 14; m++) if (stepLog.size() > m * 128) obs14[m] = stepLog[m * 128].mbit;
        checkOutput("init_key1_multiples", 128'(obs14), 128'(14'b11_1111_1111_1001));

        // Three AD bits with alternating valid, then the pad's ca boundary.
        $display("[TB] run: ad_len=3 gapped");
        key = {$urandom, $urandom, $urandom, $urandom}; iv = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(3, 0, -1, 0, 1'b0, 0);
        checkRun(3, 0);
        checkOutput("adpad_ca_edge", 128'({stepLog[1792 + 3 + 127].ca, stepLog[1792 + 3 + 128].ca}), 128'(2'b10));

        // Keystream held at 1: ciphertext is the inverted plaintext, cb low in ENC/ENC_PAD.
        $display("[TB] run: msg_len=8, ks=1");
        applyStimulus(2, 8, 60, 1, 1'b0, 0);
        checkRun(2, 8);
        checkOutput("tag_all_ones", bus.tag_o, {128{1'b1}});
        obs8 = '0; exp8 = '0;
        for (int j = 0; j < 8; j++) begin
            if (j < ctObs.size()) obs8[j] = ctObs[j];
            exp8[j] = ~ptBits[j];
        end
        checkOutput("ct_inverted", 128'(obs8), 128'(exp8));
        ones = 0;
        foreach (stepLog[k]) if ((stepLog[k].phase == 3'd5 || stepLog[k].phase == 3'd6) && stepLog[k].cb) ones++;
        checkOutput("cb_low_enc", 128'(ones), 128'(0));

        // Randomized operations.
        for (int r = 0; r < 3; r++) begin
            adL = $urandom_range(0, 40);
            msL = $urandom_range(0, 40);
            $display("[TB] run: random ad_len=%0d msg_len=%0d", adL, msL);
            key = {$urandom, $urandom, $urandom, $urandom}; iv = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(adL, msL, $urandom_range(30, 100), 0, 1'b0, 0);
            checkRun(adL, msL);
        end

        // Reset in the middle of FIN, then a clean operation.
        $display("[TB] run: reset mid-FIN");
        applyStimulus(0, 0, 50, 0, 1'b0, 1 + 1792 + 256 + 256 + 100);
        applyStimulus(6, 6, 80, 0, 1'b0, 0);
        checkRun(6, 6);

`ifdef ACORN_DECRYPT_EN
        // Decrypt: the stream carries ciphertext, mbit and ct_bit_o give back plaintext.
        $display("[TB] run: decrypt");
        applyStimulus(4, 16, 70, 0, 1'b1, 0);
        checkRun(4, 16);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acorn_phase_ctrl.md
Name: acorn_phase_ctrl

Overview:
- Sequencer for the ACORN-128 state-update datapath. Each cycle it decides whether the datapath steps, and supplies that step's message bit, ca and cb.
- Walks all phases of one authenticated encryption: load, init (1792 steps), AD, AD padding, encryption, encryption padding, finalization.
- Serially accepts AD and plaintext bits, emits ciphertext bits, and collects the 128-bit tag.

Parameters:
- AD_LEN_W, 16, width of AD bit-length input
- MSG_LEN_W, 16, width of message bit-length input
- INIT_STEPS, 1792, initialization step count
- PAD_STEPS, 256, padding steps per padding phase
- FIN_STEPS, 768, finalization step count

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  begin operation; sampled only in IDLE
- key_i  in  128  key; bit i = key_i[i]; held stable while busy_o
- iv_i  in  128  IV; bit i = iv_i[i]; held stable while busy_o
- ad_len_i  in  AD_LEN_W  AD length in bits; latched at start
- msg_len_i  in  MSG_LEN_W  message length in bits; latched at start
- ad_bit_i, ad_valid_i  in  1,1  AD bit stream
- ad_ready_o  out  1  high in AD state
- pt_bit_i, pt_valid_i  in  1,1  plaintext bit stream
- pt_ready_o  out  1  high in ENC state
- ks_bit_i  in  1  keystream bit of the current datapath state (combinational)
- state_clr_o  out  1  clear datapath state
- step_o  out  1  datapath advances at this edge
- mbit_o, ca_o, cb_o  out  1,1,1  datapath controls for this step
- ct_bit_o, ct_valid_o  out  1,1  ciphertext bit stream
- tag_o  out  128  tag; valid while tag_valid_o
- tag_valid_o  out  1  high from DONE until next start
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse in DONE
- phase_o  out  3  encoded current state

Behaviour:
- Reset: FSM to IDLE; step counter 0; tag_o 0. All other outputs 0.
- States and transitions:
  - IDLE→LOAD on start_i; latch both lengths.
  - LOAD: one cycle. state_clr_o=1, step_o=0.
  - LOAD→INIT.
- INIT: step_o=1 every cycle; ca=cb=1; count i=0..1791. mbit per step i:
  - i<128: key[i]
  - 128≤i<256: iv[i-128]
  - i=256: key[0]^1
  - otherwise: key[i mod 128]
- INIT→AD when i=1791; goes to AD_PAD instead if ad_len=0.
- AD:
  - step_o = ad_valid_i; mbit=ad_bit_i; ca=cb=1.
  - Counts accepted bits only; no step while valid is low.
  - Leave after ad_len accepted bits.
- AD_PAD: 256 steps; mbit=1 at step 0, else 0; ca=1 for steps 0–127, 0 for 128–255; cb=1.
  - AD_PAD→ENC, or →ENC_PAD if msg_len=0.
- ENC:
  - step_o = pt_valid_i; mbit=pt_bit_i; ca=1, cb=0.
  - ct_bit_o = pt_bit_i^ks_bit_i; ct_valid_o = step_o.
  - Leave after msg_len accepted bits.
- ENC_PAD: as AD_PAD, but cb=0. ENC_PAD→FIN.
- FIN: 768 steps; mbit=0, ca=cb=1. At steps 640–767, tag_o[step-640] <= ks_bit_i.
- DONE: one cycle; done_o=1, tag_valid_o set. DONE→IDLE.
- Total latency, empty AD and message: done_o is high 3074 cycles after the edge that samples start_i.
- Boundary rules:
  - start_i while busy: ignored.
  - ready outputs are 0 outside their state; valid outside AD/ENC has no effect.
  - Step counter is 11 bits; it is cleared on every state transition.
  - Length comparisons are unsigned at full width. Maximum length 2^W−1 is supported.
  - rst mid-operation: immediate return to IDLE; tag_valid_o cleared.

Optional Feature:
- Macro: ACORN_DECRYPT_EN.
- When defined:
  - Adds input dec_i, latched at start.
  - With dec=1, ENC treats pt_bit_i as ciphertext: mbit_o = pt_bit_i^ks_bit_i, and ct_bit_o carries the recovered plaintext (same XOR).
  - Step timing is unchanged.
- When undefined: encryption only; no dec_i port.

Decomposition:
- Package acorn_pkg holds:
  - the phase state enum (3-bit encoding: IDLE=0, LOAD=1, INIT=2, AD=3, AD_PAD=4, ENC=5, ENC_PAD=6, FIN=7; DONE shares its own internal encoding, with phase_o=7 plus done_o)
  - step constants 1792, 256, 128, 768, 640.
- Sub-module acorn_init_mbit: combinational init-phase mbit selector taking key, iv and step index.

Test Plan:
- key=0, iv=0, ad_len=0, msg_len=0: mbit_o is 1 only at INIT step 256. done_o arrives exactly 3074 cycles after start. tag_valid_o=1.
- key=128'h1, iv=0: in INIT, mbit_o=1 at steps 0, 384, 512, …, 1664 (every k·128 except 128 and 256); 0 at step 256.
- ad_len=3, ad_valid gapped (1,0,1,0,1): exactly 3 AD steps, then AD_PAD. Check ca drops to 0 after pad step 127.
- msg_len=8, ks_bit_i forced 1: ct_bit_o = ~pt_bit_i for 8 valid cycles; cb_o=0 throughout ENC/ENC_PAD.
- ks_bit_i=1 only in the last 128 FIN steps: tag_o=all ones. start_i pulsed mid-INIT is ignored.
- rst asserted mid-FIN: outputs zero immediately. A new start completes normally.
- Decrypt build, dec_i=1: feeding ct recovers pt; mbit_o equals the recovered plaintext.
